// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result and {N,Z,C,V} codes.
// Shifts run one bit per cycle; MUL is an unsigned shift-add over WIDTH cycles.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// BUSY  | iterating a shift or multiply, count holds remaining steps
// DONE  | result/cc valid, waiting for out_ready
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       aluop,
   input  logic [WIDTH-1:0] valA,
   input  logic [WIDTH-1:0] valB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       cc
);

   localparam logic [2:0] OP_MUL = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_SHL = 3'd3;
   localparam logic [2:0] OP_SHR = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_NOT = 3'd7;

   localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [2:0]           op_q;
   logic [WIDTH-1:0]     a_q;
   logic                 b_msb_q;
   logic [WIDTH-1:0]     sh_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic [SHW:0]         count;

   logic [WIDTH-1:0]     eff_b;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic [WIDTH-1:0]     sh_nxt;
   logic                 sh_c;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   prod_nxt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   function automatic logic [3:0] mk_cc(input logic [WIDTH-1:0] r, input logic c, input logic v);
      return {r[WIDTH-1], (r == '0), c, v};
   endfunction

   // SUB is A + ~B + 1 so carry means "no borrow" and V uses the inverted operand
   always_comb begin
      eff_b   = (aluop == OP_SUB) ? ~valB : valB;
      sum     = {1'b0, valA} + {1'b0, eff_b} + {{WIDTH{1'b0}}, (aluop == OP_SUB)};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (aluop)
         OP_ADD, OP_SUB: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (valA[WIDTH-1] == eff_b[WIDTH-1]) && (sum[WIDTH-1] != valA[WIDTH-1]);
         end
         OP_AND:  alu_res = valA & valB;
         OP_OR:   alu_res = valA | valB;
         OP_NOT:  alu_res = ~valB;
         default: alu_res = '0;
      endcase
   end

   // Multiplier sits in the low half of prod_q and is consumed LSB first
   always_comb begin
      if (op_q == OP_SHL) begin
         sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
         sh_c   = sh_q[WIDTH-1];
      end else begin
         sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
         sh_c   = sh_q[0];
      end
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
      prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         result  <= '0;
         cc      <= '0;
         count   <= '0;
         op_q    <= OP_MUL;
         a_q     <= '0;
         b_msb_q <= 1'b0;
         sh_q    <= '0;
         prod_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q    <= aluop;
                  a_q     <= valA;
                  b_msb_q <= valB[WIDTH-1];
                  sh_q    <= valB;
                  prod_q  <= {{WIDTH{1'b0}}, valB};
                  case (aluop)
                     OP_MUL: begin
                        count <= MUL_CNT;
                        state <= BUSY;
                     end
                     OP_SHL, OP_SHR: begin
                        if (valA[SHW-1:0] == '0) begin
                           result <= valB;
                           cc     <= mk_cc(valB, 1'b0, 1'b0);
                           state  <= DONE;
                        end else begin
                           count <= {1'b0, valA[SHW-1:0]};
                           state <= BUSY;
                        end
                     end
                     default: begin
                        result <= alu_res;
                        cc     <= mk_cc(alu_res, alu_c, alu_v);
                        state  <= DONE;
                     end
                  endcase
               end
            end
            BUSY: begin
               count <= count - CNT_ONE;
               if (op_q == OP_MUL) begin
                  prod_q <= prod_nxt;
                  if (count == CNT_ONE) begin
                     result <= prod_nxt[WIDTH-1:0];
                     cc     <= mk_cc(prod_nxt[WIDTH-1:0], |prod_nxt[2*WIDTH-1:WIDTH], 1'b0);
                     state  <= DONE;
                  end
               end else begin
                  sh_q <= sh_nxt;
                  if (count == CNT_ONE) begin
                     result <= sh_nxt;
                     cc     <= mk_cc(sh_nxt, sh_c, (op_q == OP_SHL) && (b_msb_q ^ sh_nxt[WIDTH-1]));
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results at accept,
// a negedge monitor compares result, cc and latency when out_valid is seen.
module tb_alu_seq;
   localparam int W = 16;
   localparam longint M = longint'(1) << W;
   localparam longint H = M / 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   aluop = 3'd0;
   logic [W-1:0] valA = '0;
   logic [W-1:0] valB = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic [3:0]   cc;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .aluop(aluop), .valA(valA), .valB(valB), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .cc(cc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] r;
      logic [3:0]   cc;
      int           lat;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   seen = 0;
   int   ordy_mode = 1;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input longint act, input longint expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned/signed views of the operands
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint ua, ub, p, sa, sb, sr;
      int     n;
      bit     c, v;
      logic [W-1:0] r;
      ua = longint'(a);
      ub = longint'(b);
      sa = (ua >= H) ? ua - M : ua;
      sb = (ub >= H) ? ub - M : ub;
      n  = int'(ua % W);
      c = 0; v = 0; e.lat = 1; e.acc = 0; r = '0;
      case (op)
         3'd0: begin p = ua * ub; r = W'(p); c = (p >> W) != 0; e.lat = W + 1; end
         3'd1: begin p = ua + ub; r = W'(p); c = p >= M; sr = sa + sb; v = (sr > H - 1) || (sr < -H); end
         3'd2: begin r = W'(ua - ub); c = ua >= ub; sr = sa - sb; v = (sr > H - 1) || (sr < -H); end
         3'd3: begin
            r = W'(ub << n);
            c = (n > 0) && (((ub >> (W - n)) & 1) != 0);
            v = b[W-1] ^ r[W-1];
            e.lat = n + 1;
         end
         3'd4: begin
            r = W'(ub >> n);
            c = (n > 0) && (((ub >> (n - 1)) & 1) != 0);
            e.lat = n + 1;
         end
         3'd5: r = a & b;
         3'd6: r = a | b;
         default: r = ~b;
      endcase
      e.r  = r;
      e.cc = {r[W-1], (r == '0), c, v};
      return e;
   endfunction

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   t;
      t = 0;
      @(negedge clk);
      aluop = op; valA = a; valB = b; in_valid = 1'b1;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         e = model(op, a, b);
         e.acc = cyc;
         q.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      ordy_mode = 1;
      while (q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ordy_mode == 2) out_ready = 1'($urandom_range(0, 1));
         else out_ready = (ordy_mode == 1);
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got result 0x%0h with no operation outstanding", result);
         end else begin
            if (!seen) begin
               chk("latency", cyc - q[0].acc, q[0].lat);
               seen = 1;
            end
            chk("result", result, q[0].r);
            chk("cc", cc, q[0].cc);
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready) begin
               void'(q.pop_front());
               seen = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result", result, 0);
      chk("reset_cc", cc, 0);
      rst = 1'b0;

      issue(3'd1, 16'h7FFF, 16'h0001);
      issue(3'd2, 16'h0005, 16'h0005);
      issue(3'd2, 16'h0000, 16'h0001);
      issue(3'd3, 16'h0003, 16'h4001);
      issue(3'd4, 16'h000F, 16'h8001);
      issue(3'd3, 16'h0010, 16'hABCD);
      issue(3'd0, 16'h0100, 16'h0100);
      issue(3'd0, 16'h00FF, 16'h0003);
      issue(3'd5, 16'hF0F0, 16'h3C3C);
      issue(3'd6, 16'hF000, 16'h000F);
      issue(3'd7, 16'h1234, 16'h0000);
      issue(3'd3, 16'h0001, 16'h8000);
      issue(3'd2, 16'h0000, 16'h8000);
      drain();

      // Backpressure: hold result in DONE while a new request is presented
      ordy_mode = 0;
      out_ready = 1'b0;
      issue(3'd1, 16'h1234, 16'h1111);
      aluop = 3'd6; valA = 16'hFFFF; valB = 16'h0F0F; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ordy_mode = 1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
      chk("release_queue", q.size(), 0);

      ordy_mode = 2;
      repeat (40) issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      drain();

      // Reset in the middle of a multiply discards it
      issue(3'd0, 16'h1234, 16'h5678);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      q.delete();
      seen = 0;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_in_ready", in_ready, 1);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_result", result, 0);
      chk("midreset_cc", cc, 0);
      issue(3'd1, 16'h0002, 16'h0003);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 16-bit combinational ALU.
- Generalises the datapath to WIDTH bits and registers the result and the N/Z/C/V condition codes.
- Adds an iterative multi-cycle shifter and a shift-add multiplier (MUL), so the datapath needs no barrel shifter or array multiplier.
- Sits between the CPU register-read stage and writeback, with valid/ready on both sides.

Parameters:
- WIDTH, 16: operand and result width; must be a power of 2, at least 4.
- SHW, $clog2(WIDTH): width of the shift amount taken from valA.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept a new operation.
- aluop  in  3  opcode: 000 MUL, 001 ADD, 010 SUB, 011 SHL, 100 SHR (logical), 101 AND, 110 OR, 111 NOT.
- valA  in  WIDTH  operand A; its low SHW bits are the shift amount for SHL/SHR.
- valB  in  WIDTH  operand B; the shifted value for SHL/SHR; the only operand for NOT.
- out_valid  out  1  result and cc are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- cc  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset (rst=1 at a clock edge): state goes to IDLE; in_ready=1, out_valid=0, result=0, cc=0, internal counter=0. Reset wins over every other event, including mid-operation; any in-flight operation is discarded with no output.
- FSM states IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- Accept: in_valid & in_ready at an edge (accept edge T). Latch aluop, valA, valB.
- IDLE, single-cycle ops (ADD/SUB/AND/OR/NOT): compute and write result/cc at edge T, then go to DONE. out_valid is high in the cycle after T.
- IDLE, SHL/SHR: load count = valA[SHW-1:0].
  - count=0: result=valB, C=0, V=0, go to DONE.
  - count>0: go to BUSY.
- IDLE, MUL: load count = WIDTH, go to BUSY.
- BUSY, shift: shift by 1 bit per cycle, with zero fill at either end. C = the last bit shifted out. Decrement the counter; go to DONE at the edge where it reaches 0. out_valid is first high n+1 cycles after T (n = shift amount).
- BUSY, MUL: unsigned shift-add over WIDTH cycles, 2*WIDTH-bit product internally. result = low WIDTH bits. out_valid is first high WIDTH+1 cycles after T.
- DONE: hold result, cc and out_valid stable until out_valid & out_ready at an edge, then go to IDLE. in_ready rises the cycle after. There is no accept/complete overlap: throughput is at most 1 operation per 2 cycles.
- in_valid outside IDLE is ignored; the source holds it until in_ready.
- Arithmetic is modulo 2^WIDTH.
  - ADD: {C,result} = valA + valB.
  - SUB: {C,result} = valA + ~valB + 1. C=1 means no borrow.
- Condition codes, computed on the final result:
  - N = result[WIDTH-1]; Z = (result == 0).
  - ADD/SUB V: signed overflow using the effective B operand (~valB for SUB).
  - SHL V = valB[WIDTH-1] ^ result[WIDTH-1]; SHR V = 0.
  - MUL: C = 1 if the product's high WIDTH bits are nonzero; V=0.
  - AND/OR/NOT: C=0, V=0.
- result and cc change only on completion (entry to DONE) or on reset. They keep their last value while IDLE/BUSY.

Test Plan:
- Reset, then ADD 0x7FFF+0x0001 accepted at T -> out_valid at T+1; result 0x8000; cc N=1,Z=0,C=0,V=1.
- SUB 0x0005-0x0005 -> result 0x0000; cc N=0,Z=1,C=1,V=0. Also SUB 0x0000-0x0001 -> 0xFFFF; N=1,C=0,V=0.
- SHL valB=0x4001, valA=0x0003 -> out_valid at T+4; result 0x0008; C=0, V=0. Also SHR valB=0x8001, valA=0x000F -> result 0x0001 at T+16; C=0. Also SHL with valA=0x0010 (low bits 0) -> result=valB at T+1.
- MUL 0x0100*0x0100 -> out_valid at T+17; result 0x0000; Z=1, C=1. Also MUL 0x00FF*0x0003 -> result 0x02FD; C=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result/cc stable, in_ready=0, a new in_valid is ignored. Release -> in_ready=1 the next cycle.
- Reset asserted at BUSY cycle 8 of a MUL -> next cycle in_ready=1, out_valid=0, result=0, cc=0. A following ADD 2+3 -> result 0x0005 with normal latency.
